// File: rtl/lighthouse_pkg.sv
// Shared types and clock-derived timing constants for the lighthouse pulse decoder.
// Every timing threshold is computed from the system clock frequency.
package lighthouse_pkg;

  localparam int unsigned WidthBits = 16;
  localparam int unsigned TimerBits = 19;

  typedef enum logic [1:0] {
    StIdle,
    StWaitSync,
    StArmed
  } state_e;

  typedef enum logic [1:0] {
    PulseNone,
    PulseSync,
    PulseSweep,
    PulseError
  } pulse_class_e;

  function automatic int unsigned sync_base(input int unsigned clk_hz);
    return clk_hz / 16000;
  endfunction

  function automatic int unsigned sync_step(input int unsigned clk_hz);
    return clk_hz / 96000;
  endfunction

  function automatic int unsigned sweep_max(input int unsigned clk_hz);
    return clk_hz / 48000;
  endfunction

  function automatic int unsigned window(input int unsigned clk_hz);
    return clk_hz / 120;
  endfunction

  // Inclusive lower / exclusive upper width bound for sync code n.
  function automatic int unsigned sync_lo(input int unsigned clk_hz, input int unsigned code);
    return sync_base(clk_hz) + code * sync_step(clk_hz) - sync_step(clk_hz) / 2;
  endfunction

  function automatic int unsigned sync_hi(input int unsigned clk_hz, input int unsigned code);
    return sync_base(clk_hz) + code * sync_step(clk_hz) + sync_step(clk_hz) / 2;
  endfunction

endpackage

// File: rtl/envelope_pulse_meter.sv
// Synchronizes the TS4231 envelope line, measures each low pulse and classifies it
// as sync (with code), sweep or error on the rising edge.
module envelope_pulse_meter
  import lighthouse_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 48_000_000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         envelope_n,
  output logic         pulse_fall,
  output logic         pulse_strobe,
  output pulse_class_e pulse_class,
  output logic [2:0]   pulse_code,
  output logic [15:0]  pulse_width
);

  localparam int unsigned SweepMax = sweep_max(CLK_FREQ_HZ);

  logic        env_meta_q, env_meta_d;
  logic        env_sync_q, env_sync_d;
  logic        env_prev_q, env_prev_d;
  logic        in_pulse_q, in_pulse_d;
  logic [15:0] width_q, width_d;
  logic        fall, rise;
  logic [31:0] width_ext;

  always_ff @(posedge clock) begin
    if (reset) begin
      env_meta_q <= 1'b1;
      env_sync_q <= 1'b1;
      env_prev_q <= 1'b1;
      in_pulse_q <= 1'b0;
      width_q    <= '0;
    end else begin
      env_meta_q <= env_meta_d;
      env_sync_q <= env_sync_d;
      env_prev_q <= env_prev_d;
      in_pulse_q <= in_pulse_d;
      width_q    <= width_d;
    end
  end

  always_comb begin
    env_meta_d = envelope_n;
    env_sync_d = env_meta_q;
    env_prev_d = env_sync_q;
    fall       = env_prev_q & ~env_sync_q;
    rise       = ~env_prev_q & env_sync_q;
    in_pulse_d = in_pulse_q;
    width_d    = width_q;
    // A pulse only counts if its falling edge was seen while enabled.
    if (!enable) begin
      in_pulse_d = 1'b0;
      width_d    = '0;
    end else if (fall) begin
      in_pulse_d = 1'b1;
      width_d    = 16'd1;
    end else if (in_pulse_q && !env_sync_q) begin
      if (width_q != 16'hFFFF) begin
        width_d = width_q + 16'd1;
      end
    end else if (rise) begin
      in_pulse_d = 1'b0;
    end
  end

  always_comb begin
    width_ext    = {16'b0, width_q};
    pulse_fall   = enable & fall;
    pulse_strobe = enable & in_pulse_q & rise;
    pulse_width  = width_q;
    pulse_class  = PulseNone;
    pulse_code   = '0;
    if (pulse_strobe) begin
      pulse_class = PulseError;
      if (width_q == 16'hFFFF) begin
        pulse_class = PulseError;
      end else if (width_ext < SweepMax) begin
        pulse_class = PulseSweep;
      end else begin
        for (int unsigned n = 0; n < 8; n++) begin
          if (width_ext >= sync_lo(CLK_FREQ_HZ, n) && width_ext < sync_hi(CLK_FREQ_HZ, n)) begin
            pulse_class = PulseSync;
            pulse_code  = 3'(n);
          end
        end
      end
    end
  end

endmodule

// File: rtl/lighthouse_pulse_decoder.sv
// Lighthouse sync/sweep decoder: tracks sync codes, times the sweep relative to the
// sync falling edge and presents samples through a valid/ready holding register.
module lighthouse_pulse_decoder
  import lighthouse_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 48_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        envelope_n,
  input  logic        sample_ready,
  output logic        sample_valid,
  output logic [18:0] sample_ticks,
  output logic        sample_axis,
  output logic        sample_data,
  output logic        sample_overrun,
  output logic        pulse_error
);

  localparam logic [18:0] WindowTicks = 19'(window(CLK_FREQ_HZ));

  logic         m_fall, m_strobe;
  pulse_class_e m_class;
  logic [2:0]   m_code;
  logic [15:0]  m_width;

  state_e      state_q, state_d;
  logic [18:0] timer_q, timer_d;
  logic [18:0] fall_ticks_q, fall_ticks_d;
  logic        arm_axis_q, arm_axis_d;
  logic        arm_data_q, arm_data_d;
  logic        valid_q, valid_d;
  logic [18:0] ticks_q, ticks_d;
  logic        axis_q, axis_d;
  logic        data_q, data_d;
  logic        overrun_q, overrun_d;
  logic        perr_q, perr_d;
  logic        is_arm, emit;
  logic [18:0] sweep_ticks;

  envelope_pulse_meter #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_meter (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .envelope_n  (envelope_n),
    .pulse_fall  (m_fall),
    .pulse_strobe(m_strobe),
    .pulse_class (m_class),
    .pulse_code  (m_code),
    .pulse_width (m_width)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      fall_ticks_q <= '0;
      arm_axis_q   <= 1'b0;
      arm_data_q   <= 1'b0;
      valid_q      <= 1'b0;
      ticks_q      <= '0;
      axis_q       <= 1'b0;
      data_q       <= 1'b0;
      overrun_q    <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      fall_ticks_q <= fall_ticks_d;
      arm_axis_q   <= arm_axis_d;
      arm_data_q   <= arm_data_d;
      valid_q      <= valid_d;
      ticks_q      <= ticks_d;
      axis_q       <= axis_d;
      data_q       <= data_d;
      overrun_q    <= overrun_d;
      perr_q       <= perr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    fall_ticks_d = fall_ticks_q;
    arm_axis_d   = arm_axis_q;
    arm_data_d   = arm_data_q;
    valid_d      = valid_q;
    ticks_d      = ticks_q;
    axis_d       = axis_q;
    data_d       = data_q;
    overrun_d    = overrun_q;
    perr_d       = m_strobe && (m_class == PulseError);
    is_arm       = m_strobe && (m_class == PulseSync) && !m_code[2];
    emit         = 1'b0;
    sweep_ticks  = fall_ticks_q + {4'b0, m_width[15:1]};

    if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        timer_d = '0;
        if (enable) begin
          state_d = StWaitSync;
        end
      end
      StWaitSync: begin
        timer_d = '0;
        // The sync rise is seen width cycles after its fall, so the timer resumes at width+1.
        if (is_arm) begin
          arm_axis_d = m_code[0];
          arm_data_d = m_code[1];
          timer_d    = 19'(m_width) + 19'd1;
          state_d    = StArmed;
        end
      end
      StArmed: begin
        timer_d = timer_q + 19'd1;
        if (m_fall) begin
          fall_ticks_d = timer_q;
        end
        if (timer_q >= WindowTicks) begin
          state_d = StWaitSync;
          timer_d = '0;
        end else if (is_arm) begin
          arm_axis_d = m_code[0];
          arm_data_d = m_code[1];
          timer_d    = 19'(m_width) + 19'd1;
        end else if (m_strobe && (m_class == PulseSweep)) begin
          emit    = 1'b1;
          state_d = StWaitSync;
          timer_d = '0;
        end else if (m_strobe && (m_class == PulseError)) begin
          state_d = StWaitSync;
          timer_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase

    if (emit) begin
      if (valid_q && !sample_ready) begin
        overrun_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        ticks_d = sweep_ticks;
        axis_d  = arm_axis_q;
        data_d  = arm_data_q;
      end
    end

    if (!enable) begin
      state_d = StIdle;
      timer_d = '0;
    end
  end

  assign sample_valid   = valid_q;
  assign sample_ticks   = ticks_q;
  assign sample_axis    = axis_q;
  assign sample_data    = data_q;
  assign sample_overrun = overrun_q;
  assign pulse_error    = perr_q;

endmodule

// File: tb/tb_lighthouse_pulse_decoder.sv
// Directed bench for lighthouse_pulse_decoder, run at a reduced clock frequency so
// SYNC_BASE=60, SYNC_STEP=10, SWEEP_MAX=20, WINDOW=8000 keep the run short.
module tb_lighthouse_pulse_decoder;

  localparam int unsigned ClkHz = 960_000;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        envelope_n;
  logic        sample_ready;
  logic        sample_valid;
  logic [18:0] sample_ticks;
  logic        sample_axis;
  logic        sample_data;
  logic        sample_overrun;
  logic        pulse_error;

  int n_checks = 0;
  int n_fail   = 0;

  lighthouse_pulse_decoder #(
    .CLK_FREQ_HZ(ClkHz)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .envelope_n    (envelope_n),
    .sample_ready  (sample_ready),
    .sample_valid  (sample_valid),
    .sample_ticks  (sample_ticks),
    .sample_axis   (sample_axis),
    .sample_data   (sample_data),
    .sample_overrun(sample_overrun),
    .pulse_error   (pulse_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic gap(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse(input int len);
    envelope_n = 1'b0;
    gap(len);
    envelope_n = 1'b1;
  endtask

  task automatic consume();
    sample_ready = 1'b1;
    gap(1);
    sample_ready = 1'b0;
    gap(20);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; envelope_n = 1'b1; sample_ready = 1'b0;
    gap(3);
    n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", sample_valid); end
    n_checks++; if (sample_ticks !== 19'd0) begin n_fail++; $display("FAIL reset_ticks: got %0d want 0", sample_ticks); end
    n_checks++; if (sample_axis !== 1'b0) begin n_fail++; $display("FAIL reset_axis: got %0b want 0", sample_axis); end
    n_checks++; if (sample_data !== 1'b0) begin n_fail++; $display("FAIL reset_data: got %0b want 0", sample_data); end
    n_checks++; if (sample_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %0b want 0", sample_overrun); end
    n_checks++; if (pulse_error !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %0b want 0", pulse_error); end
    reset = 1'b0; enable = 1'b1;
    gap(4);
  endtask

  task automatic test_basic_sweep();
    pulse(60); gap(900); pulse(4);
    gap(2);
    n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %0b want 0", sample_valid); end
    gap(1);
    n_checks++; if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b want 1", sample_valid); end
    n_checks++; if (sample_ticks !== 19'd962) begin n_fail++; $display("FAIL basic_ticks: got %0d want 962", sample_ticks); end
    n_checks++; if (sample_axis !== 1'b0) begin n_fail++; $display("FAIL basic_axis: got %0b want 0", sample_axis); end
    n_checks++; if (sample_data !== 1'b0) begin n_fail++; $display("FAIL basic_data: got %0b want 0", sample_data); end
    gap(5);
    n_checks++; if (sample_ticks !== 19'd962) begin n_fail++; $display("FAIL basic_hold: got %0d want 962", sample_ticks); end
    sample_ready = 1'b1;
    gap(1);
    sample_ready = 1'b0;
    n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drop: got %0b want 0", sample_valid); end
    gap(20);
  endtask

  task automatic test_skip_sync();
    pulse(70); gap(330); pulse(100); gap(1500); pulse(2);
    gap(3);
    n_checks++; if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL skip_valid: got %0b want 1", sample_valid); end
    n_checks++; if (sample_ticks !== 19'd2001) begin n_fail++; $display("FAIL skip_ticks: got %0d want 2001", sample_ticks); end
    n_checks++; if (sample_axis !== 1'b1) begin n_fail++; $display("FAIL skip_axis: got %0b want 1", sample_axis); end
    n_checks++; if (sample_data !== 1'b0) begin n_fail++; $display("FAIL skip_data: got %0b want 0", sample_data); end
    consume();
  endtask

  task automatic test_data_codes();
    pulse(90); gap(210); pulse(10);
    gap(3);
    n_checks++; if (sample_ticks !== 19'd305) begin n_fail++; $display("FAIL code3_ticks: got %0d want 305", sample_ticks); end
    n_checks++; if ({sample_data, sample_axis} !== 2'b11) begin n_fail++; $display("FAIL code3_bits: got %b want 11", {sample_data, sample_axis}); end
    consume();
    pulse(80); gap(220); pulse(6);
    gap(3);
    n_checks++; if (sample_ticks !== 19'd303) begin n_fail++; $display("FAIL code2_ticks: got %0d want 303", sample_ticks); end
    n_checks++; if ({sample_data, sample_axis} !== 2'b10) begin n_fail++; $display("FAIL code2_bits: got %b want 10", {sample_data, sample_axis}); end
    consume();
    // Width 55 is the lowest code-0 sync width.
    pulse(55); gap(145); pulse(8);
    gap(3);
    n_checks++; if (sample_ticks !== 19'd204) begin n_fail++; $display("FAIL edge55_ticks: got %0d want 204", sample_ticks); end
    consume();
  endtask

  task automatic test_window();
    pulse(60); gap(7980); pulse(4);
    gap(3);
    n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL window_valid: got %0b want 0", sample_valid); end
    gap(20);
  endtask

  task automatic test_errors();
    pulse(40); gap(3);
    n_checks++; if (pulse_error !== 1'b1) begin n_fail++; $display("FAIL err40_strobe: got %0b want 1", pulse_error); end
    gap(1);
    n_checks++; if (pulse_error !== 1'b0) begin n_fail++; $display("FAIL err40_one_cycle: got %0b want 0", pulse_error); end
    gap(5);
    pulse(20); gap(3);
    n_checks++; if (pulse_error !== 1'b1) begin n_fail++; $display("FAIL err20_strobe: got %0b want 1", pulse_error); end
    gap(5);
    pulse(54); gap(3);
    n_checks++; if (pulse_error !== 1'b1) begin n_fail++; $display("FAIL err54_strobe: got %0b want 1", pulse_error); end
    gap(5);
    pulse(19); gap(3);
    n_checks++; if (pulse_error !== 1'b0) begin n_fail++; $display("FAIL sweep19_perr: got %0b want 0", pulse_error); end
    n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL sweep19_valid: got %0b want 0", sample_valid); end
    gap(5);
    pulse(60); gap(40); pulse(40); gap(3);
    n_checks++; if (pulse_error !== 1'b1) begin n_fail++; $display("FAIL armed_err_strobe: got %0b want 1", pulse_error); end
    gap(200); pulse(4); gap(3);
    n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL armed_err_disarm: got %0b want 0", sample_valid); end
    gap(5);
    pulse(65611); gap(3);
    n_checks++; if (pulse_error !== 1'b1) begin n_fail++; $display("FAIL saturate_strobe: got %0b want 1", pulse_error); end
    gap(100); pulse(4); gap(3);
    n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL saturate_no_arm: got %0b want 0", sample_valid); end
    gap(20);
  endtask

  task automatic test_overrun();
    sample_ready = 1'b0;
    pulse(60); gap(440); pulse(6); gap(3);
    n_checks++; if (sample_ticks !== 19'd503) begin n_fail++; $display("FAIL ovr_first_ticks: got %0d want 503", sample_ticks); end
    n_checks++; if (sample_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first_flag: got %0b want 0", sample_overrun); end
    gap(20);
    pulse(70); gap(530); pulse(8); gap(3);
    n_checks++; if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %0b want 1", sample_valid); end
    n_checks++; if (sample_ticks !== 19'd503) begin n_fail++; $display("FAIL ovr_held_ticks: got %0d want 503", sample_ticks); end
    n_checks++; if (sample_axis !== 1'b0) begin n_fail++; $display("FAIL ovr_held_axis: got %0b want 0", sample_axis); end
    n_checks++; if (sample_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %0b want 1", sample_overrun); end
    sample_ready = 1'b1;
    gap(1);
    sample_ready = 1'b0;
    n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drop: got %0b want 0", sample_valid); end
    n_checks++; if (sample_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %0b want 1", sample_overrun); end
    gap(20);
  endtask

  task automatic test_reset_enable();
    pulse(90); gap(210); pulse(10); gap(3);
    pulse(60); gap(100);
    reset = 1'b1;
    gap(2);
    reset = 1'b0;
    n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", sample_valid); end
    n_checks++; if (sample_ticks !== 19'd0) begin n_fail++; $display("FAIL rst_ticks: got %0d want 0", sample_ticks); end
    n_checks++; if ({sample_data, sample_axis} !== 2'b00) begin n_fail++; $display("FAIL rst_bits: got %b want 00", {sample_data, sample_axis}); end
    n_checks++; if (sample_overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %0b want 0", sample_overrun); end
    gap(200); pulse(4); gap(3);
    n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_sample: got %0b want 0", sample_valid); end
    gap(20);
    // Enable dropped mid-pulse: the remainder must not be measured as a sync.
    envelope_n = 1'b0;
    gap(10);
    enable = 1'b0;
    gap(1);
    enable = 1'b1;
    gap(62);
    envelope_n = 1'b1;
    gap(240); pulse(4); gap(3);
    n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL en_discard: got %0b want 0", sample_valid); end
    gap(20);
    pulse(60); gap(240); pulse(4); gap(3);
    n_checks++; if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL resume_valid: got %0b want 1", sample_valid); end
    n_checks++; if (sample_ticks !== 19'd302) begin n_fail++; $display("FAIL resume_ticks: got %0d want 302", sample_ticks); end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_skip_sync();
    test_data_codes();
    test_window();
    test_errors();
    test_overrun();
    test_reset_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
